periph_write_initiator: RTL and testbench
=========================================

PERIPH_WRITE_INITIATOR -- requirements
Module: periph_write_initiator

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 64'h0000_0000, peripheral window base.
REQ-002 SHALL have parameter WIN_SIZE, default 64'h0000_0010, peripheral window size in bytes.
REQ-003 SHALL have parameter TIMEOUT, default 16, max cycles to wait for ready.
REQ-004 SHALL have port ACLK  input  1  the only clock; all logic on its rising edge.
REQ-005 SHALL have port ARESETn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port CoreWriteValid  input  1  core write request valid.
REQ-007 SHALL have port CoreWriteReady  output  1  initiator can accept a request.
REQ-008 SHALL have port CoreWriteAddr  input  64  absolute write address.
REQ-009 SHALL have port CoreWriteData  input  64  write data.
REQ-010 SHALL have port CoreWriteStrb  input  4  byte strobes.
REQ-011 SHALL have port CoreRespValid  output  1  one-cycle write completion pulse.
REQ-012 SHALL have port CoreRespErr  output  1  completion status; 1 = decode error or timeout, valid with CoreRespValid.
REQ-013 SHALL have port WriteAddr  output  64  peripheral-relative offset.
REQ-014 SHALL have port WriteData  output  64  peripheral write data.
REQ-015 SHALL have port WriteEnable  output  1  peripheral write strobe.
REQ-016 SHALL have port WriteStrb  output  4  peripheral byte strobes.
REQ-017 SHALL have port SlaverWriteReady  input  1  peripheral write acknowledge.

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: CoreWriteReady=1; handshake = CoreWriteValid & CoreWriteReady; on handshake, request fields SHALL be registered.
REQ-020 Decode: BASE_ADDR <= addr < BASE_ADDR+WIN_SIZE hits (unsigned 64-bit compare); hit -> ISSUE, miss -> RESP with error, no peripheral cycle.
REQ-021 WriteAddr SHALL equal registered addr minus BASE_ADDR (64-bit, no wrap possible on hit).
REQ-022 ISSUE: WriteEnable=1 for exactly this first cycle, then -> WAIT; SlaverWriteReady in ISSUE SHALL be ignored (stale-ready immunity).
REQ-023 WAIT: WriteEnable stays 1, address/data/strobe stable; SlaverWriteReady=1 -> RESP without error, WriteEnable deasserts next cycle.
REQ-024 WAIT: timeout counter counts WAIT cycles; count reaching TIMEOUT without ready -> RESP with error; ready on the same cycle as expiry SHALL win (no error).
REQ-025 RESP: CoreRespValid=1 for exactly one cycle with CoreRespErr; -> IDLE.
REQ-026 CoreWriteReady SHALL be 0 in ISSUE, WAIT, RESP; one outstanding write only.
REQ-027 Latency: hit with ready on first WAIT cycle = handshake + 3 cycles to CoreRespValid; decode miss = handshake + 1.
REQ-028 WriteEnable, WriteAddr, WriteData, WriteStrb SHALL be registered outputs; WriteEnable=0 outside ISSUE/WAIT; WriteAddr/WriteData/WriteStrb hold last values when idle.
REQ-029 CoreWriteStrb == 4'b0000 on a hit SHALL still issue the peripheral write (strobe passed through unmodified).

Reset
REQ-030 While ARESETn=0 at a rising edge: state=IDLE, timeout counter=0, WriteEnable=0, WriteAddr=0, WriteData=0, WriteStrb=0, CoreRespValid=0, CoreRespErr=0.
REQ-031 Reset mid-transaction SHALL abandon it silently: no CoreRespValid issued for it; WriteEnable=0 from the reset edge.
REQ-032 CoreWriteReady SHALL be 0 while ARESETn=0 and 1 the first cycle after release.

Structure
REQ-033 Data width 64 and state encodings SHALL live in the shared defines file alongside the existing bus width macros.
REQ-034 Timeout counter SHALL be sub-module periph_wr_timeout (inputs: clear, enable; output: expired), width clog2(TIMEOUT+1).

Verification
REQ-035 Hit write addr 0x4, data 0x55, strb 4'hF, ready asserted 1 cycle into WAIT -> WriteAddr=0x4, WriteEnable high 2 cycles, CoreRespValid=1, Err=0, 3 cycles after handshake.
REQ-036 BASE_ADDR=0x1000, write 0x2000 -> no WriteEnable, CoreRespValid+Err=1 next cycle.
REQ-037 Hit write, SlaverWriteReady held 0 -> CoreRespValid+Err=1 after 16 WAIT cycles; WriteEnable drops after.
REQ-038 SlaverWriteReady stuck 1 from before request -> ignored in ISSUE, accepted first WAIT cycle, Err=0.
REQ-039 ARESETn=0 during WAIT -> no response pulse, WriteEnable=0 next edge, CoreWriteReady=1 after release.
REQ-040 Back-to-back requests with CoreWriteValid held high -> second accepted only cycle after CoreRespValid, both completed in order.

Source files
------------

// File: rtl/periph_write_initiator_pkg.sv
// Shared widths, FSM encodings and request payload for the peripheral write initiator.
package periph_write_initiator_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Registered request as presented to the peripheral (window-relative offset).
  typedef struct packed {
    logic [ADDR_W-1:0] offset;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } wr_req_t;

  // base <= addr < base + size, written so base + size can never overflow.
  function automatic logic win_hit(input logic [ADDR_W-1:0] addr,
                                   input logic [ADDR_W-1:0] base,
                                   input logic [ADDR_W-1:0] size);
    return (addr >= base) && ((addr - base) < size);
  endfunction

endpackage

// File: rtl/periph_write_initiator_if.sv
// Core-side write request/response channel of the peripheral write initiator.
interface periph_write_initiator_if;
  import periph_write_initiator_pkg::*;

  logic              CoreWriteValid;
  logic              CoreWriteReady;
  logic [ADDR_W-1:0] CoreWriteAddr;
  logic [DATA_W-1:0] CoreWriteData;
  logic [STRB_W-1:0] CoreWriteStrb;
  logic              CoreRespValid;
  logic              CoreRespErr;

  modport master (
    output CoreWriteValid, CoreWriteAddr, CoreWriteData, CoreWriteStrb,
    input  CoreWriteReady, CoreRespValid, CoreRespErr
  );

  modport slave (
    input  CoreWriteValid, CoreWriteAddr, CoreWriteData, CoreWriteStrb,
    output CoreWriteReady, CoreRespValid, CoreRespErr
  );

endinterface

// File: rtl/periph_wr_timeout.sv
// Counts WAIT cycles and flags the cycle on which the count reaches TIMEOUT.
module periph_wr_timeout #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned LIMIT = (TIMEOUT == 0) ? 1 : TIMEOUT;
  localparam int unsigned CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0] SAT  = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != SAT)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // High during the WAIT cycle whose completion brings the count to TIMEOUT.
  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/periph_write_initiator.sv
// Single-outstanding write initiator: decodes a core write against a peripheral
// window, drives the peripheral strobe until acknowledge or timeout, then responds.
module periph_write_initiator
  import periph_write_initiator_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 64'h0000_0000,
  parameter logic [ADDR_W-1:0] WIN_SIZE  = 64'h0000_0010,
  parameter int unsigned       TIMEOUT   = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  periph_write_initiator_if.slave core,
  output logic [ADDR_W-1:0]       WriteAddr,
  output logic [DATA_W-1:0]       WriteData,
  output logic                    WriteEnable,
  output logic [STRB_W-1:0]       WriteStrb,
  input  logic                    SlaverWriteReady
);

  logic [1:0] state_q, state_d;
  wr_req_t    req_q, req_d;
  logic       we_q, we_d;
  logic       rv_q, rv_d;
  logic       re_q, re_d;
  logic       handshake;
  logic       hit;
  logic       tmo_expired;
  logic       in_wait;

  assign core.CoreWriteReady = ARESETn && (state_q == ST_IDLE);
  assign handshake           = core.CoreWriteValid && core.CoreWriteReady;
  assign hit                 = win_hit(core.CoreWriteAddr, BASE_ADDR, WIN_SIZE);
  assign in_wait             = (state_q == ST_WAIT);

  periph_wr_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .clear   (!in_wait),
    .enable  (in_wait),
    .expired (tmo_expired)
  );

  // Next state; registered outputs are derived from the state being entered.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    re_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          if (hit) begin
            state_d      = ST_ISSUE;
            req_d.offset = core.CoreWriteAddr - BASE_ADDR;
            req_d.data   = core.CoreWriteData;
            req_d.strb   = core.CoreWriteStrb;
          end else begin
            state_d = ST_RESP;
            re_d    = 1'b1;
          end
        end
      end
      // Acknowledge is not looked at here so a ready left high from before is ignored.
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (SlaverWriteReady) begin
          state_d = ST_RESP;
        end else if (tmo_expired) begin
          state_d = ST_RESP;
          re_d    = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    we_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
    rv_d = (state_d == ST_RESP);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      we_q    <= 1'b0;
      rv_q    <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      rv_q    <= rv_d;
      re_q    <= re_d;
    end
  end

  assign WriteAddr          = req_q.offset;
  assign WriteData          = req_q.data;
  assign WriteStrb          = req_q.strb;
  assign WriteEnable        = we_q;
  assign core.CoreRespValid = rv_q;
  assign core.CoreRespErr   = re_q;

  // Completion is always a single-cycle pulse.
  resp_single_pulse: assert property (@(posedge ACLK) disable iff (!ARESETn)
    core.CoreRespValid |=> !core.CoreRespValid);

endmodule

// File: tb/tb_periph_write_initiator.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// random writes compared against a cycle-count model of the initiator.
module tb_periph_write_initiator;
  import periph_write_initiator_pkg::*;

  localparam logic [63:0] BASE = 64'h1000;
  localparam logic [63:0] WIN  = 64'h10;
  localparam int unsigned TMO  = 16;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [63:0] WriteAddr;
  logic [63:0] WriteData;
  logic        WriteEnable;
  logic [3:0]  WriteStrb;
  logic        SlaverWriteReady;

  int checks   = 0;
  int failures = 0;

  logic [63:0] last_off;
  logic [63:0] last_data;
  logic [3:0]  last_strb;

  periph_write_initiator_if core_if ();

  periph_write_initiator #(
    .BASE_ADDR (BASE),
    .WIN_SIZE  (WIN),
    .TIMEOUT   (TMO)
  ) dut (
    .ACLK             (ACLK),
    .ARESETn          (ARESETn),
    .core             (core_if),
    .WriteAddr        (WriteAddr),
    .WriteData        (WriteData),
    .WriteEnable      (WriteEnable),
    .WriteStrb        (WriteStrb),
    .SlaverWriteReady (SlaverWriteReady)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [3:0]  strb;
    int          d;        // WAIT cycles before the peripheral acknowledges (>= TMO: never)
    logic        early;    // acknowledge already high before the request
    int          exp_lat;  // cycles from handshake to CoreRespValid
    logic        exp_err;
    int          exp_we;   // cycles WriteEnable is high
  } vec_t;

  vec_t vecs[11];

  task automatic check(input int id, input string what, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL id=%0d %s actual=0x%0h required=0x%0h", id, what, act, exp);
    end
  endtask

  // Behavioural expectation: window decode, then ready-vs-timeout race in whole cycles.
  function automatic void model(input logic [63:0] addr, input int d,
                                output int lat, output logic err, output int wec);
    logic hit;
    hit = (addr >= BASE) && (addr < BASE + WIN);
    if (!hit) begin
      lat = 1; err = 1'b1; wec = 0;
    end else if (d < int'(TMO)) begin
      lat = 3 + d; err = 1'b0; wec = lat - 1;
    end else begin
      lat = 2 + int'(TMO); err = 1'b1; wec = lat - 1;
    end
  endfunction

  task automatic wait_idle(input int id);
    int waited;
    waited = 0;
    while (core_if.CoreWriteReady !== 1'b1 && waited < 50) begin
      @(negedge ACLK);
      waited++;
    end
    check(id, "idle_ready", 64'(core_if.CoreWriteReady), 64'd1);
  endtask

  task automatic run_txn(input int id, input logic [63:0] addr, input logic [63:0] data,
                         input logic [3:0] strb, input int d, input logic early,
                         input int exp_lat, input logic exp_err, input int exp_we);
    int lat, wec;
    logic got, err_seen, fld_ok, busy_ok;
    logic [63:0] off;
    wait_idle(id);
    off = addr - BASE;
    core_if.CoreWriteValid = 1'b1;
    core_if.CoreWriteAddr  = addr;
    core_if.CoreWriteData  = data;
    core_if.CoreWriteStrb  = strb;
    SlaverWriteReady       = early;
    lat = 0; wec = 0; got = 1'b0; err_seen = 1'b0; fld_ok = 1'b1; busy_ok = 1'b1;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge ACLK);
      if (c == 1) core_if.CoreWriteValid = 1'b0;
      if (core_if.CoreWriteReady !== 1'b0) busy_ok = 1'b0;
      if (WriteEnable === 1'b1) begin
        wec++;
        if (WriteAddr !== off || WriteData !== data || WriteStrb !== strb) fld_ok = 1'b0;
      end
      if (core_if.CoreRespValid === 1'b1) begin
        got = 1'b1;
        lat = c;
        err_seen = core_if.CoreRespErr;
      end else begin
        SlaverWriteReady = early || (c >= 2 + d);
      end
    end
    SlaverWriteReady = 1'b0;
    check(id, "resp_latency", 64'(lat), 64'(exp_lat));
    check(id, "resp_err", 64'(err_seen), 64'(exp_err));
    check(id, "we_cycles", 64'(wec), 64'(exp_we));
    check(id, "periph_fields", 64'(fld_ok), 64'd1);
    check(id, "busy_not_ready", 64'(busy_ok), 64'd1);
    @(negedge ACLK);
    check(id, "resp_one_cycle", 64'(core_if.CoreRespValid), 64'd0);
    check(id, "we_after_resp", 64'(WriteEnable), 64'd0);
    if (exp_we > 0) begin
      last_off  = off;
      last_data = data;
      last_strb = strb;
    end
    check(id, "hold_addr", WriteAddr, last_off);
    check(id, "hold_data", WriteData, last_data);
    check(id, "hold_strb", 64'(WriteStrb), 64'(last_strb));
  endtask

  // Valid held high over two requests; acknowledge held high throughout.
  task automatic back_to_back();
    int hs2, r1, r2, nhs, nr;
    logic e1, e2, addr_ok;
    logic [63:0] a1, a2;
    a1 = BASE + 64'h4;
    a2 = BASE + 64'hC;
    wait_idle(200);
    core_if.CoreWriteValid = 1'b1;
    core_if.CoreWriteAddr  = a1;
    core_if.CoreWriteData  = 64'h1111;
    core_if.CoreWriteStrb  = 4'hF;
    SlaverWriteReady       = 1'b1;
    nhs = 1; nr = 0; hs2 = -1; r1 = -1; r2 = -1; e1 = 1'b1; e2 = 1'b1; addr_ok = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge ACLK);
      if (WriteEnable === 1'b1 && WriteAddr !== ((nhs >= 2) ? (a2 - BASE) : (a1 - BASE)))
        addr_ok = 1'b0;
      if (core_if.CoreRespValid === 1'b1) begin
        if (nr == 0) begin r1 = c; e1 = core_if.CoreRespErr; end
        else if (nr == 1) begin r2 = c; e2 = core_if.CoreRespErr; end
        nr++;
      end
      if (core_if.CoreWriteReady === 1'b1 && core_if.CoreWriteValid === 1'b1) begin
        if (nhs == 1) hs2 = c;
        nhs++;
      end else if (nhs >= 2) begin
        core_if.CoreWriteValid = 1'b0;
      end
      if (c == 1) begin
        core_if.CoreWriteAddr = a2;
        core_if.CoreWriteData = 64'h2222;
      end
    end
    SlaverWriteReady       = 1'b0;
    core_if.CoreWriteValid = 1'b0;
    check(200, "b2b_resp1_cycle", 64'(r1), 64'd3);
    check(200, "b2b_second_accept", 64'(hs2), 64'd4);
    check(200, "b2b_resp2_cycle", 64'(r2), 64'd7);
    check(200, "b2b_errs", 64'({e1, e2}), 64'd0);
    check(200, "b2b_resp_count", 64'(nr), 64'd2);
    check(200, "b2b_addr_order", 64'(addr_ok), 64'd1);
    last_off  = a2 - BASE;
    last_data = 64'h2222;
    last_strb = 4'hF;
  endtask

  // Reset asserted while the peripheral write is stalled in WAIT.
  task automatic reset_mid();
    logic seen;
    wait_idle(300);
    core_if.CoreWriteValid = 1'b1;
    core_if.CoreWriteAddr  = BASE + 64'h8;
    core_if.CoreWriteData  = 64'h5A5A;
    core_if.CoreWriteStrb  = 4'hF;
    SlaverWriteReady       = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge ACLK);
      if (c == 1) core_if.CoreWriteValid = 1'b0;
    end
    check(300, "mid_we_active", 64'(WriteEnable), 64'd1);
    ARESETn = 1'b0;
    @(negedge ACLK);
    check(300, "rst_we", 64'(WriteEnable), 64'd0);
    check(300, "rst_ready", 64'(core_if.CoreWriteReady), 64'd0);
    check(300, "rst_resp", 64'(core_if.CoreRespValid), 64'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check(300, "rel_ready", 64'(core_if.CoreWriteReady), 64'd1);
    check(300, "rel_addr", WriteAddr, 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge ACLK);
      if (core_if.CoreRespValid !== 1'b0) seen = 1'b1;
    end
    check(300, "no_orphan_resp", 64'(seen), 64'd0);
    last_off  = '0;
    last_data = '0;
    last_strb = '0;
  endtask

  initial begin
    int lat, wec, d;
    logic err, early;
    logic [63:0] addr;
    int unsigned pick;

    vecs[0]  = '{64'h1004, 64'h55,        4'hF, 0,  1'b0, 3,  1'b0, 2};
    vecs[1]  = '{64'h2000, 64'hAA,        4'hF, 0,  1'b0, 1,  1'b1, 0};
    vecs[2]  = '{64'h1008, 64'h1234,      4'h3, 99, 1'b0, 18, 1'b1, 17};
    vecs[3]  = '{64'h100C, 64'hDEAD_BEEF, 4'hF, 0,  1'b1, 3,  1'b0, 2};
    vecs[4]  = '{64'h1000, 64'h77,        4'h0, 0,  1'b0, 3,  1'b0, 2};
    vecs[5]  = '{64'h100F, 64'hCAFE,      4'h5, 2,  1'b0, 5,  1'b0, 4};
    vecs[6]  = '{64'h1010, 64'h11,        4'hF, 0,  1'b0, 1,  1'b1, 0};
    vecs[7]  = '{64'h0FFF, 64'h22,        4'hF, 0,  1'b0, 1,  1'b1, 0};
    vecs[8]  = '{64'h1004, 64'h0102_0304_0506_0708, 4'hA, 15, 1'b0, 18, 1'b0, 17};
    vecs[9]  = '{64'h1004, 64'h99,        4'h6, 16, 1'b0, 18, 1'b1, 17};
    vecs[10] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'h1, 0, 1'b0, 1, 1'b1, 0};

    ARESETn                = 1'b0;
    core_if.CoreWriteValid = 1'b0;
    core_if.CoreWriteAddr  = '0;
    core_if.CoreWriteData  = '0;
    core_if.CoreWriteStrb  = '0;
    SlaverWriteReady       = 1'b0;
    last_off  = '0;
    last_data = '0;
    last_strb = '0;

    repeat (3) @(negedge ACLK);
    check(0, "reset_ready", 64'(core_if.CoreWriteReady), 64'd0);
    check(0, "reset_we", 64'(WriteEnable), 64'd0);
    check(0, "reset_addr", WriteAddr, 64'd0);
    check(0, "reset_data", WriteData, 64'd0);
    check(0, "reset_strb", 64'(WriteStrb), 64'd0);
    check(0, "reset_resp_valid", 64'(core_if.CoreRespValid), 64'd0);
    check(0, "reset_resp_err", 64'(core_if.CoreRespErr), 64'd0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check(0, "release_ready", 64'(core_if.CoreWriteReady), 64'd1);

    for (int i = 0; i < 11; i++)
      run_txn(i + 1, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].d, vecs[i].early,
              vecs[i].exp_lat, vecs[i].exp_err, vecs[i].exp_we);

    back_to_back();

    for (int i = 0; i < 40; i++) begin
      pick = $urandom_range(0, 9);
      if (pick < 7)       addr = BASE + 64'($urandom_range(0, 15));
      else if (pick == 7) addr = BASE + WIN + 64'($urandom_range(0, 3));
      else if (pick == 8) addr = BASE - 64'd1 - 64'($urandom_range(0, 3));
      else                addr = {$urandom, $urandom};
      pick = $urandom_range(0, 9);
      if (pick < 7)       d = int'($urandom_range(0, 4));
      else if (pick == 7) d = int'($urandom_range(13, 16));
      else                d = 99;
      early = (d == 0) && ($urandom_range(0, 1) == 1);
      model(addr, d, lat, err, wec);
      run_txn(100 + i, addr, {$urandom, $urandom}, 4'($urandom_range(0, 15)), d, early, lat, err, wec);
    end

    reset_mid();
    run_txn(400, vecs[0].addr, vecs[0].data, vecs[0].strb, vecs[0].d, vecs[0].early,
            vecs[0].exp_lat, vecs[0].exp_err, vecs[0].exp_we);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
